// File: rtl/dmem_responder_pkg.sv
// Shared pipeline definitions for the MEM-stage data responder:
// FSM state encoding, operation encoding and the address fault decode.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  localparam int DATA_W  = 16;
  localparam int COUNT_W = 4;

  // Misaligned byte address, or any address bit above the word index set.
  function automatic logic addr_fault(input logic [15:0] addr, input int depth_log2);
    logic [15:0] hi;
    hi = addr >> (depth_log2 + 1);
    return addr[0] || (hi != 16'd0);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Stalling request/response bundle between the MEM stage (master) and the responder (slave).
interface dmem_responder_if;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic        createdump;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        err;

  modport master (
    output Addr, DataIn, Rd, Wr, createdump,
    input  DataOut, Done, Stall, err
  );

  modport slave (
    input  Addr, DataIn, Rd, Wr, createdump,
    output DataOut, Done, Stall, err
  );
endinterface

// File: rtl/dff_en.sv
// Single-bit enabled flop with asynchronous active-high clear.
module dff_en (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic d_i,
  output logic q_o
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q_o <= 1'b0;
    else if (en_i) q_o <= d_i;
  end
endmodule

// File: rtl/dmem_array.sv
// Word-addressed 16-bit data array: combinational read, clocked write, contents never cleared.
module dmem_array #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] idx_i,
  input  logic [15:0]           wdata_i,
  output logic [15:0]           rdata_o
);
  logic [15:0] mem_q [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
  end

  assign rdata_o = mem_q[idx_i];
endmodule

// File: rtl/reg16bit.sv
// 16-bit enabled register assembled from dff_en cells.
module reg16bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic [15:0] d_i,
  output logic [15:0] q_o
);
  for (genvar gi = 0; gi < 16; gi++) begin : g_bit
    dff_en u_bit (
      .clk  (clk),
      .rst  (rst),
      .en_i (en_i),
      .d_i  (d_i[gi]),
      .q_o  (q_o[gi])
    );
  end
endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one request, stalls the MEM stage for
// LATENCY cycles, then pulses Done with read data / fault status.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);
  localparam logic [COUNT_W-1:0] LAST_BUSY = COUNT_W'(LATENCY - 1);

  state_e               state_q, state_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 accept;
  logic                 done;
  logic [15:0]          addr_q;
  logic [DATA_W-1:0]    data_q;
  logic                 op_q;
  logic                 fault_q;
  logic                 op_d;
  logic                 fault_d;
  logic                 we;
  logic [15:0]          rdata;
  logic [DEPTH_LOG2-1:0] idx;
  logic                 unused_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    accept  = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.Rd || bus.Wr) begin
          accept  = 1'b1;
          count_d = COUNT_W'(1);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (count_q == LAST_BUSY) begin
          count_d = '0;
          state_d = ST_DONE;
        end else begin
          count_d = count_q + COUNT_W'(1);
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latches capture only on acceptance; later input changes are ignored.
  assign op_d    = bus.Wr ? OP_WR : OP_RD;
  assign fault_d = (bus.Rd && bus.Wr) || addr_fault(bus.Addr, DEPTH_LOG2);

  reg16bit u_addr (.clk(clk), .rst(rst), .en_i(accept), .d_i(bus.Addr),   .q_o(addr_q));
  reg16bit u_data (.clk(clk), .rst(rst), .en_i(accept), .d_i(bus.DataIn), .q_o(data_q));
  dff_en   u_op   (.clk(clk), .rst(rst), .en_i(accept), .d_i(op_d),       .q_o(op_q));
  dff_en   u_flt  (.clk(clk), .rst(rst), .en_i(accept), .d_i(fault_d),    .q_o(fault_q));

  assign idx         = addr_q[DEPTH_LOG2:1];
  assign unused_addr = ^addr_q;

  // Write lands on the edge that leaves DONE, so an aborting reset drops it.
  assign we = done && (op_q == OP_WR) && !fault_q;

  dmem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk     (clk),
    .we_i    (we),
    .idx_i   (idx),
    .wdata_i (data_q),
    .rdata_o (rdata)
  );

  assign bus.Done    = done;
  assign bus.err     = done && fault_q;
  assign bus.DataOut = (done && (op_q == OP_RD) && !fault_q) ? rdata : 16'd0;
  assign bus.Stall   = (state_q == ST_BUSY) ||
                       ((state_q == ST_IDLE) && (bus.Rd || bus.Wr) && !rst);

`ifdef SIM
  logic dump_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dump_q <= 1'b0;
    else     dump_q <= bus.createdump;
  end

  always @(posedge clk) begin
    if (!rst && (state_q == ST_IDLE) && bus.createdump && !dump_q) begin
      for (int i = 0; i < (1 << DEPTH_LOG2); i++) begin
        $display("dump %04h %04h", i[15:0], u_array.mem_q[i]);
      end
    end
  end
`else
  logic unused_dump;
  assign unused_dump = bus.createdump;
`endif

endmodule
